// File: rtl/lcd_rgb_capture.sv
// Receive side of the RGB565 panel link: recovers pixel coordinates, measures line/frame
// geometry, checks a white border, sums each frame and writes a 64x64 window to capture RAM.
module lcd_rgb_capture #(
  parameter int H_ACT = 800,
  parameter int V_ACT = 480
) (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic        i_vid_den,
  input  logic        i_vid_hsync,
  input  logic        i_vid_vsync,
  input  logic [4:0]  i_vid_r,
  input  logic [5:0]  i_vid_g,
  input  logic [4:0]  i_vid_b,
  input  logic [15:0] i_win_x,
  input  logic [15:0] i_win_y,
  output logic [15:0] o_meas_h_total,
  output logic [15:0] o_meas_h_active,
  output logic [15:0] o_meas_v_total,
  output logic [15:0] o_meas_v_active,
  output logic [15:0] o_frame_sum,
  output logic        o_border_ok,
  output logic        o_locked,
  output logic        o_frame_done,
  output logic        o_cap_we,
  output logic [11:0] o_cap_addr,
  output logic [15:0] o_cap_data
);
  // state   | meaning
  // SEARCH  | no frame start seen yet; pixels ignored
  // MEASURE | framing, last two frames' geometry differed
  // LOCKED  | last two frames' geometry identical
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      r_state;
  logic        r_pend;
  logic        r_den1, r_hs1, r_vs1, r_den2, r_hs2, r_vs2;
  logic [15:0] r_pix1;
  logic [15:0] r_hclk, r_px, r_ly, r_htot, r_hact, r_vtot, r_sum;
  logic        r_bflag;
  logic [15:0] r_win_x, r_win_y;
  logic [15:0] r_snap_ht, r_snap_ha, r_snap_vt, r_snap_va, r_snap_sum;
  logic        r_snap_bflag;

  logic        w_hs_fall, w_vs_fall, w_de_fall;
  logic [15:0] w_px, w_ly, w_ox, w_oy;
  logic        w_border, w_bbad, w_in_win, w_same;

  assign w_hs_fall = !r_hs1 && r_hs2;
  assign w_vs_fall = !r_vs1 && r_vs2;
  assign w_de_fall = !r_den1 && r_den2;
  // Coordinates of the pixel currently in S1; a coincident sync fall restarts them at 0.
  assign w_px      = w_hs_fall ? 16'd0 : r_px;
  assign w_ly      = w_vs_fall ? 16'd0 : r_ly;
  assign w_ox      = w_px - r_win_x;
  assign w_oy      = w_ly - r_win_y;
  assign w_border  = (w_px == 16'd0) || (w_px == 16'(H_ACT - 1)) ||
                     (w_ly == 16'd0) || (w_ly == 16'(V_ACT - 1));
  assign w_bbad    = r_den1 && w_border && (r_pix1 != 16'hFFFF);
  assign w_in_win  = r_den1 && (w_ox < 16'd64) && (w_oy < 16'd64);
  assign w_same    = (r_snap_ht == o_meas_h_total) && (r_snap_ha == o_meas_h_active) &&
                     (r_snap_vt == o_meas_v_total) && (r_snap_va == o_meas_v_active);

  always_ff @(posedge clk_pix or negedge reset) begin
    if (!reset) begin
      {r_den1, r_den2} <= 2'b00;
      {r_hs1, r_hs2, r_vs1, r_vs2} <= 4'hF;
      r_pix1 <= '0;  r_hclk <= '0;  r_px <= '0;   r_ly <= '0;
      r_htot <= '0;  r_hact <= '0;  r_vtot <= '0; r_sum <= '0;
      r_bflag <= 1'b0;
      r_win_x <= '0; r_win_y <= '0;
      r_snap_ht <= '0; r_snap_ha <= '0; r_snap_vt <= '0; r_snap_va <= '0;
      r_snap_sum <= '0; r_snap_bflag <= 1'b0;
      o_cap_we <= 1'b0; o_cap_addr <= '0; o_cap_data <= '0;
    end else begin
      r_den1 <= i_vid_den;
      r_hs1  <= i_vid_hsync;
      r_vs1  <= i_vid_vsync;
      r_pix1 <= {i_vid_r, i_vid_g, i_vid_b};
      r_den2 <= r_den1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_hclk <= w_hs_fall ? 16'd0 : sat_inc(r_hclk);
      r_px   <= w_hs_fall ? {15'd0, r_den1} : (r_den1 ? sat_inc(r_px) : r_px);
      if (w_hs_fall) r_htot <= sat_inc(r_hclk);
      if (w_de_fall) r_hact <= r_px;
      if (w_vs_fall) begin
        // Frame boundary first: close out the old frame, then let coincident events seed the new one.
        r_snap_ht    <= r_htot;
        r_snap_ha    <= r_hact;
        r_snap_vt    <= r_vtot;
        r_snap_va    <= r_ly;
        r_snap_sum   <= r_sum;
        r_snap_bflag <= r_bflag;
        r_win_x      <= i_win_x;
        r_win_y      <= i_win_y;
        r_vtot       <= w_hs_fall ? 16'd1 : 16'd0;
        r_ly         <= '0;
        r_sum        <= r_den1 ? r_pix1 : 16'd0;
        r_bflag      <= !w_bbad;
        if (!w_hs_fall) r_htot <= '0;
        if (!w_de_fall) r_hact <= '0;
      end else begin
        if (w_hs_fall) r_vtot <= sat_inc(r_vtot);
        if (w_de_fall) r_ly <= sat_inc(r_ly);
        if (r_den1)    r_sum <= r_sum + r_pix1;
        if (w_bbad)    r_bflag <= 1'b0;
      end
      o_cap_we <= (r_state != SEARCH) && w_in_win;
      if (w_in_win) begin
        o_cap_addr <= {w_oy[5:0], w_ox[5:0]};
        o_cap_data <= r_pix1;
      end
    end
  end

  always_ff @(posedge clk_pix or negedge reset) begin
    if (!reset) begin
      r_state         <= SEARCH;
      r_pend          <= 1'b0;
      o_meas_h_total  <= '0;
      o_meas_h_active <= '0;
      o_meas_v_total  <= '0;
      o_meas_v_active <= '0;
      o_frame_sum     <= '0;
      o_border_ok     <= 1'b0;
      o_locked        <= 1'b0;
      o_frame_done    <= 1'b0;
    end else begin
      r_pend       <= 1'b0;
      o_frame_done <= 1'b0;
      if (w_vs_fall) begin
        if (r_state == SEARCH) r_state <= MEASURE;
        else                   r_pend  <= 1'b1;
      end
      if (r_pend) begin
        o_frame_done    <= 1'b1;
        o_meas_h_total  <= r_snap_ht;
        o_meas_h_active <= r_snap_ha;
        o_meas_v_total  <= r_snap_vt;
        o_meas_v_active <= r_snap_va;
        o_frame_sum     <= r_snap_sum;
        o_border_ok     <= r_snap_bflag && (r_snap_ha == 16'(H_ACT)) && (r_snap_va == 16'(V_ACT));
        if (w_same) begin
          r_state  <= LOCKED;
          o_locked <= 1'b1;
        end else begin
          r_state  <= MEASURE;
          o_locked <= 1'b0;
        end
      end
    end
  end
endmodule
